// File: rtl/weight_loader.sv
// Streams host words into per-neuron weight and bias write strobes for one layer.
// Each neuron takes numWeight weight words followed by one bias word.
module weight_loader #(
  parameter int unsigned layerNo   = 1,
  parameter int unsigned numNeuron = 4,
  parameter int unsigned numWeight = 5,
  parameter int unsigned dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 weightValid,
  output logic [dataWidth-1:0] weightValue,
  output logic                 biasValid,
  output logic [31:0]          biasValue,
  output logic [31:0]          config_layer_num,
  output logic [31:0]          config_neuron_num,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NCW = $clog2(numNeuron) + 1;
  localparam int unsigned WCW = $clog2(numWeight) + 1;
  localparam logic [NCW-1:0] N_LAST = NCW'(numNeuron - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(numWeight - 1);

  typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, DONE} state_t;

  state_t               state_q, state_d;
  logic [NCW-1:0]       n_cnt_q, n_cnt_d;
  logic [WCW-1:0]       w_cnt_q, w_cnt_d;
  logic                 ready_q, ready_d;
  logic                 wv_q, wv_d;
  logic [dataWidth-1:0] wval_q, wval_d;
  logic                 bv_q, bv_d;
  logic [31:0]          bval_q, bval_d;
  logic [31:0]          layer_q, layer_d;
  logic [31:0]          neuron_q, neuron_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 xfer;
  logic                 last_xfer;

  // Next-state, counters and strobe payloads
  always_comb begin
    state_d   = state_q;
    n_cnt_d   = n_cnt_q;
    w_cnt_d   = w_cnt_q;
    wv_d      = 1'b0;
    wval_d    = wval_q;
    bv_d      = 1'b0;
    bval_d    = bval_q;
    layer_d   = 32'd0;
    neuron_d  = neuron_q;
    done_d    = done_q;
    last_xfer = 1'b0;
    xfer      = s_valid && ready_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WEIGHT;
          n_cnt_d = '0;
          w_cnt_d = '0;
        end
      end
      WEIGHT: begin
        if (xfer) begin
          wv_d     = 1'b1;
          wval_d   = s_data[dataWidth-1:0];
          neuron_d = 32'(n_cnt_q);
          layer_d  = 32'(layerNo);
          if (w_cnt_q == W_LAST) begin
            w_cnt_d = '0;
            state_d = BIAS;
          end else begin
            w_cnt_d = w_cnt_q + WCW'(1);
          end
        end
      end
      BIAS: begin
        if (xfer) begin
          bv_d     = 1'b1;
          bval_d   = s_data;
          neuron_d = 32'(n_cnt_q);
          layer_d  = 32'(layerNo);
          if (n_cnt_q == N_LAST) begin
            state_d   = DONE;
            done_d    = 1'b1;
            last_xfer = 1'b1;
          end else begin
            n_cnt_d = n_cnt_q + NCW'(1);
            state_d = WEIGHT;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = WEIGHT;
          n_cnt_d = '0;
          w_cnt_d = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == WEIGHT) || (state_d == BIAS);
    // busy covers the cycle of the final bias strobe as well
    busy_d  = ready_d || last_xfer;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_cnt_q  <= '0;
      w_cnt_q  <= '0;
      ready_q  <= 1'b0;
      wv_q     <= 1'b0;
      wval_q   <= '0;
      bv_q     <= 1'b0;
      bval_q   <= '0;
      layer_q  <= '0;
      neuron_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_cnt_q  <= n_cnt_d;
      w_cnt_q  <= w_cnt_d;
      ready_q  <= ready_d;
      wv_q     <= wv_d;
      wval_q   <= wval_d;
      bv_q     <= bv_d;
      bval_q   <= bval_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign s_ready           = ready_q;
  assign weightValid       = wv_q;
  assign weightValue       = wval_q;
  assign biasValid         = bv_q;
  assign biasValue         = bval_q;
  assign config_layer_num  = layer_q;
  assign config_neuron_num = neuron_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: two configurations (2x3 and 3x1) share one stimulus
// stream and are each compared every cycle against a pass-position model.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'd0;

  logic        rdy[2], wv[2], bv[2], bsy[2], dn[2];
  logic [15:0] wval[2];
  logic [31:0] bval[2], lay[2], neu[2];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  weight_loader #(.layerNo(1), .numNeuron(2), .numWeight(3), .dataWidth(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy[0]), .weightValid(wv[0]), .weightValue(wval[0]),
    .biasValid(bv[0]), .biasValue(bval[0]), .config_layer_num(lay[0]),
    .config_neuron_num(neu[0]), .busy(bsy[0]), .done(dn[0]));

  weight_loader #(.layerNo(3), .numNeuron(3), .numWeight(1), .dataWidth(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy[1]), .weightValid(wv[1]), .weightValue(wval[1]),
    .biasValid(bv[1]), .biasValue(bval[1]), .config_layer_num(lay[1]),
    .config_neuron_num(neu[1]), .busy(bsy[1]), .done(dn[1]));

  // Model: a pass is a flat sequence of numNeuron*(numWeight+1) words;
  // position p belongs to neuron p/(numWeight+1) and is the bias when p%(numWeight+1)==numWeight.
  int          m_phase[2];  // 0 idle, 1 loading, 2 done
  int          m_pos[2];
  logic [31:0] e_rdy[2], e_wv[2], e_wval[2], e_bv[2], e_bval[2];
  logic [31:0] e_lay[2], e_neu[2], e_bsy[2], e_dn[2];

  function automatic int nn_of(input int k); return (k == 0) ? 2 : 3; endfunction
  function automatic int nw_of(input int k); return (k == 0) ? 3 : 1; endfunction
  function automatic int layer_of(input int k); return (k == 0) ? 1 : 3; endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input int k, input logic r, input logic st, input logic sv,
                            input logic [31:0] d);
    int  per;
    bit  fin;
    per = nw_of(k) + 1;
    fin = 1'b0;
    e_wv[k]  = 0;
    e_bv[k]  = 0;
    e_lay[k] = 0;
    if (r) begin
      m_phase[k] = 0; m_pos[k] = 0;
      e_wval[k] = 0; e_bval[k] = 0; e_neu[k] = 0;
    end else begin
      case (m_phase[k])
        0, 2: if (st) begin m_phase[k] = 1; m_pos[k] = 0; end
        default: if (sv) begin
          e_neu[k] = 32'(m_pos[k] / per);
          e_lay[k] = 32'(layer_of(k));
          if (m_pos[k] % per == nw_of(k)) begin
            e_bv[k] = 1; e_bval[k] = d;
          end else begin
            e_wv[k] = 1; e_wval[k] = {16'd0, d[15:0]};
          end
          m_pos[k]++;
          if (m_pos[k] == nn_of(k) * per) begin m_phase[k] = 2; fin = 1'b1; end
        end
      endcase
    end
    e_rdy[k] = (m_phase[k] == 1) ? 1 : 0;
    e_bsy[k] = (m_phase[k] == 1 || fin) ? 1 : 0;
    e_dn[k]  = (m_phase[k] == 2) ? 1 : 0;
  endtask

  task automatic step(input logic r, input logic st, input logic sv, input logic [31:0] d);
    rst = r; start = st; s_valid = sv; s_data = d;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_edge(k, r, st, sv, d);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d.s_ready", k), 32'(rdy[k]), e_rdy[k]);
      check($sformatf("d%0d.weightValid", k), 32'(wv[k]), e_wv[k]);
      check($sformatf("d%0d.weightValue", k), 32'(wval[k]), e_wval[k]);
      check($sformatf("d%0d.biasValid", k), 32'(bv[k]), e_bv[k]);
      check($sformatf("d%0d.biasValue", k), bval[k], e_bval[k]);
      check($sformatf("d%0d.layer", k), lay[k], e_lay[k]);
      check($sformatf("d%0d.neuron", k), neu[k], e_neu[k]);
      check($sformatf("d%0d.busy", k), 32'(bsy[k]), e_bsy[k]);
      check($sformatf("d%0d.done", k), 32'(dn[k]), e_dn[k]);
    end
  endtask

  task automatic word(input logic [31:0] d); step(1'b0, 1'b0, 1'b1, d); endtask
  task automatic idle_cycle(); step(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF); endtask

  initial begin
    logic [31:0] words[8];
    words = '{32'd1, 32'd2, 32'd3, 32'hA, 32'd4, 32'd5, 32'd6, 32'hB};
    for (int k = 0; k < 2; k++) begin m_phase[k] = 0; m_pos[k] = 0; end

    repeat (3) step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check("reset.ready", 32'(rdy[0]), 32'd0);

    // Valid words in IDLE are ignored
    repeat (2) word(32'h5555_AAAA);

    // Full 2x3 pass with valid held high
    step(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) word(words[i]);
    check("final.biasValue", bval[0], 32'hB);
    check("final.done", 32'(dn[0]), 32'd1);
    check("final.busy", 32'(bsy[0]), 32'd1);
    idle_cycle();
    check("done_hold", 32'(dn[0]), 32'd1);
    check("busy_after", 32'(bsy[0]), 32'd0);

    // Start in DONE restarts; stall after second word; truncation word
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("restart.done", 32'(dn[0]), 32'd0);
    check("restart.ready", 32'(rdy[0]), 32'd1);
    word(32'h1111_0001);
    word(32'h2222_0002);
    repeat (3) idle_cycle();
    word(32'h1234_5678);
    check("trunc.weightValue", 32'(wval[0]), 32'h5678);
    check("trunc.neuron", neu[0], 32'd0);
    // Start while busy is ignored
    step(1'b0, 1'b1, 1'b1, 32'h0000_00C0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) word(32'h100 + 32'(i));

    // Reset after the 4th transfer, then a clean pass
    step(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) word(32'h200 + 32'(i));
    step(1'b1, 1'b1, 1'b1, 32'h0BAD_0BAD);
    check("midrst.neuron", neu[0], 32'd0);
    check("midrst.weightValue", 32'(wval[0]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    word(32'h300);
    check("post_rst.neuron", neu[0], 32'd0);
    check("post_rst.wv", 32'(wv[0]), 32'd1);
    for (int i = 1; i < 8; i++) word(32'h300 + 32'(i));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
